hdmi_fetch_ctrl: RTL and testbench
==================================

# hdmi_fetch_ctrl

Frame-buffer fetch sequencer for the HDMI output path. It converts the video core's frame-level pulses (`read_go`, `read_done`) and pixel consumption strobe (`read_fifo`) into a stream of bounded burst read requests to the memory master. Requests are throttled by a credit counter so the pixel FIFO between memory and the core can never overflow. The block also flags pixel underflow and counts completed frames.

## Interface
- `ADDR_W`, 32, byte address width
- `BURST_BEATS`, 64, max pixels (32-bit words) per burst; power of two
- `FIFO_DEPTH`, 512, pixel FIFO capacity in words; must be ≥ `BURST_BEATS`

- `clock` in 1: sole clock
- `reset_n` in 1: asynchronous, active-low reset
- `enable` in 1: fetch permitted
- `frame_base` in ADDR_W: byte address of pixel (0,0)
- `line_stride` in 16: bytes between line starts
- `hres` in 11: active pixels per line, 1..2047
- `vres` in 11: active lines per frame, 1..2047
- `read_go` in 1: one-cycle pulse, frame start
- `read_done` in 1: one-cycle pulse, frame end
- `read_fifo` in 1: one pixel popped from FIFO this cycle
- `rd_req` out 1: burst request valid
- `rd_addr` out ADDR_W: burst start byte address
- `rd_len` out 8: burst length in words, 1..BURST_BEATS
- `rd_ack` in 1: request accepted when `rd_req && rd_ack`
- `busy` out 1: state ≠ IDLE
- `underflow` out 1: sticky; pop with no credited data
- `frame_count` out 16: completed frames, wraps

## Operation
- States: IDLE, FETCH, REQ, DRAIN.
- IDLE: on `read_go && enable` load `line_addr = frame_base`, `addr = frame_base`, `line_idx = 0`, `px_left = hres`, and go to FETCH.
- FETCH: `len = min(px_left, BURST_BEATS)`. If `credit + len <= FIFO_DEPTH`, drive `rd_req`/`rd_addr = addr`/`rd_len = len` and go to REQ. Otherwise wait.
- REQ: hold `rd_req`, `rd_addr` and `rd_len` stable until `rd_ack`. On the ack: `credit += len`, `addr += 4*len`, `px_left -= len`.
  - If `px_left` becomes 0 and `line_idx == vres-1`, go to DRAIN.
  - If `px_left` becomes 0 on an earlier line: `line_idx++`, `line_addr += line_stride`, `addr = line_addr`, `px_left = hres`, then FETCH.
  - Otherwise go to FETCH.
- DRAIN: on `read_done`, `frame_count++` and go to IDLE.
- Bursts per line = ceil(hres/BURST_BEATS). Example: hres=800 gives 12×64 plus one burst of 32.
- Credit counter, width `clog2(FIFO_DEPTH)+1`:
  - `+len` on handshake, `-1` on `read_fifo`; a simultaneous handshake and pop gives `+len-1`.
  - `read_fifo` with credit 0 sets `underflow`; credit stays 0 and never goes negative.
  - Credit is not cleared on frame boundaries.
- `read_go` outside IDLE restarts the frame:
  - From FETCH or DRAIN it takes effect next cycle.
  - From REQ it is latched and applied after `rd_ack`. The completed burst's credit is still counted.
- `enable` low:
  - In FETCH or DRAIN, go to IDLE next cycle.
  - In REQ, complete the handshake first, then go to IDLE.
  - `read_go` is ignored while `enable` is low.
- Address arithmetic is modulo 2^ADDR_W and wraps silently.
- `hres` and `vres` are sampled only at frame start; changes mid-frame are ignored.

## Timing
- Reset values: `rd_req` 0, `rd_addr` 0, `rd_len` 0, `busy` 0, `underflow` 0, `frame_count` 0. State IDLE, credit 0.
- All outputs are registered.
- `read_go` at cycle N: `busy` = 1 at N+1, first `rd_req` at N+2 (IDLE→FETCH→REQ).
- After `rd_ack` at cycle M, the next `rd_req` is no earlier than M+2 (REQ→FETCH→REQ).
- `underflow` rises the cycle after the offending pop and clears only on reset.
- `frame_count` increments the cycle after `read_done` in DRAIN.

## Configuration
- `HDMI_FETCH_DBLBUF_EN` defined:
  - `frame_base` and `line_stride` are copied into shadow registers only at accepted `read_go`.
  - Software may update both freely mid-frame; changes apply from the next frame.
- Not defined:
  - `frame_base` is sampled only at frame start.
  - `line_stride` is used live at each line advance.

## Structure
- Package `hdmi_fetch_pkg`:
  - State enumeration.
  - Default `BURST_BEATS` and `FIFO_DEPTH` constants.
  - `min` length helper function.
- Sub-module `hdmi_fetch_credit`:
  - Saturating credit counter with `add_en`, `add_len`, `pop`, `credit` and `underflow`.
  - Verified standalone.
- Top level holds the FSM and address/line registers.

## Test plan
- hres=800, vres=2, `rd_ack` tied 1, no pops -> bursts of 64×12 then 32 per line. Line 1 starts at `frame_base + line_stride`. Fetch stalls at credit 512: first 8 bursts only, then waits.
- Credit limit: 512 credit, then a single `read_fifo` pop -> no request. After 64 pops -> next `rd_req` issued. Simultaneous `rd_ack` and pop -> credit + len - 1.
- Stall handshake: `rd_ack` held 0 for 10 cycles -> `rd_req`, `rd_addr`, `rd_len` stable throughout.
- Underflow: `read_fifo` at credit 0 -> `underflow` = 1 next cycle, credit stays 0, remains set until `reset_n` low.
- Restart: `read_go` mid-REQ -> current burst completes on `rd_ack`, then next request at `frame_base` with `rd_len` 64.
- Full frame: hres=640, vres=480, consumer pops continuously -> exactly 4800 bursts, `read_done` in DRAIN gives `frame_count` 1. Async reset mid-frame -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/hdmi_fetch_pkg.sv
// hdmi_fetch_pkg -- shared FSM state type, default sizing and burst-length helper.
// Rev 1.0
`default_nettype none

package hdmi_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_REQ   = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  localparam int DEF_BURST_BEATS = 64;
  localparam int DEF_FIFO_DEPTH  = 512;

  function automatic logic [10:0] min_len(input logic [10:0] a, input logic [10:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hdmi_fetch_credit.sv
// hdmi_fetch_credit -- pixel FIFO credit counter with sticky underflow flag.
// Rev 1.0
`default_nettype none

module hdmi_fetch_credit
  import hdmi_fetch_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int LEN_W      = 8
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        add_en,
  input  logic [LEN_W-1:0]            add_len,
  input  logic                        pop,
  output logic [$clog2(FIFO_DEPTH):0] credit,
  output logic                        underflow
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [CW-1:0] credit_q, credit_d;
  logic          underflow_q, underflow_d;

  // A pop with nothing credited is discarded, so the count never goes negative
  always_comb begin
    credit_d    = credit_q;
    underflow_d = underflow_q;
    if (add_en) credit_d = credit_q + CW'(add_len);
    if (pop) begin
      if (credit_q == '0) underflow_d = 1'b1;
      else                credit_d    = credit_d - CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      credit_q    <= '0;
      underflow_q <= 1'b0;
    end else begin
      credit_q    <= credit_d;
      underflow_q <= underflow_d;
    end
  end

  assign credit    = credit_q;
  assign underflow = underflow_q;

endmodule

`default_nettype wire

// File: rtl/hdmi_fetch_ctrl.sv
// hdmi_fetch_ctrl -- frame-buffer burst fetch sequencer; HDMI_FETCH_DBLBUF_EN shadows line_stride per frame.
// Rev 1.0
`default_nettype none

module hdmi_fetch_ctrl
  import hdmi_fetch_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int BURST_BEATS = DEF_BURST_BEATS,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [ADDR_W-1:0] frame_base,
  input  logic [15:0]       line_stride,
  input  logic [10:0]       hres,
  input  logic [10:0]       vres,
  input  logic              read_go,
  input  logic              read_done,
  input  logic              read_fifo,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_len,
  input  logic              rd_ack,
  output logic              busy,
  output logic              underflow,
  output logic [15:0]       frame_count
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, line_addr_q, line_addr_d, rd_addr_q, rd_addr_d;
  logic [10:0]       line_idx_q, line_idx_d, px_left_q, px_left_d;
  logic [10:0]       hres_q, hres_d, vres_q, vres_d;
  logic [7:0]        rd_len_q, rd_len_d;
  logic              rd_req_q, rd_req_d, busy_q, busy_d;
  logic              go_pend_q, go_pend_d, stop_pend_q, stop_pend_d;
  logic [15:0]       frame_count_q, frame_count_d;
  logic [15:0]       stride;

  logic [$clog2(FIFO_DEPTH):0] credit;
  logic        hs, go_ok, fits, load;
  logic [10:0] len, px_rem;

`ifdef HDMI_FETCH_DBLBUF_EN
  // frame_base needs no extra shadow: it is only read when a frame is loaded
  logic [15:0] stride_q, stride_d;
  assign stride = stride_q;
`else
  assign stride = line_stride;
`endif

  assign hs     = rd_req_q & rd_ack;
  assign go_ok  = read_go & enable;
  assign len    = min_len(px_left_q, 11'(BURST_BEATS));
  assign fits   = (32'(credit) + 32'(len)) <= 32'(FIFO_DEPTH);
  assign px_rem = px_left_q - 11'(rd_len_q);

  hdmi_fetch_credit #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .LEN_W      (8)
  ) u_credit (
    .clock     (clock),
    .reset_n   (reset_n),
    .add_en    (hs),
    .add_len   (rd_len_q),
    .pop       (read_fifo),
    .credit    (credit),
    .underflow (underflow)
  );

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    line_addr_d   = line_addr_q;
    line_idx_d    = line_idx_q;
    px_left_d     = px_left_q;
    hres_d        = hres_q;
    vres_d        = vres_q;
    rd_req_d      = rd_req_q;
    rd_addr_d     = rd_addr_q;
    rd_len_d      = rd_len_q;
    go_pend_d     = go_pend_q;
    stop_pend_d   = stop_pend_q;
    frame_count_d = frame_count_q;
`ifdef HDMI_FETCH_DBLBUF_EN
    stride_d      = stride_q;
`endif
    load          = 1'b0;

    case (state_q)
      ST_IDLE: if (go_ok) load = 1'b1;
      ST_FETCH: begin
        if (!enable)      state_d = ST_IDLE;
        else if (read_go) load    = 1'b1;
        else if (fits) begin
          state_d   = ST_REQ;
          rd_req_d  = 1'b1;
          rd_addr_d = addr_q;
          rd_len_d  = len[7:0];
        end
      end
      ST_REQ: begin
        // Restart and stop requests wait for the handshake in flight
        if (go_ok)   go_pend_d   = 1'b1;
        if (!enable) stop_pend_d = 1'b1;
        if (hs) begin
          rd_req_d    = 1'b0;
          go_pend_d   = 1'b0;
          stop_pend_d = 1'b0;
          state_d     = ST_FETCH;
          if (stop_pend_q || !enable)  state_d = ST_IDLE;
          else if (go_pend_q || read_go) load = 1'b1;
          else if (px_rem == 11'd0) begin
            if (line_idx_q == vres_q - 11'd1) state_d = ST_DRAIN;
            else begin
              line_idx_d  = line_idx_q + 11'd1;
              line_addr_d = line_addr_q + ADDR_W'(stride);
              addr_d      = line_addr_q + ADDR_W'(stride);
              px_left_d   = hres_q;
            end
          end else begin
            addr_d    = addr_q + ADDR_W'({rd_len_q, 2'b00});
            px_left_d = px_rem;
          end
        end
      end
      ST_DRAIN: begin
        if (read_done)      frame_count_d = frame_count_q + 16'd1;
        if (!enable)        state_d = ST_IDLE;
        else if (read_go)   load    = 1'b1;
        else if (read_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      state_d     = ST_FETCH;
      line_addr_d = frame_base;
      addr_d      = frame_base;
      line_idx_d  = 11'd0;
      px_left_d   = hres;
      hres_d      = hres;
      vres_d      = vres;
`ifdef HDMI_FETCH_DBLBUF_EN
      stride_d    = line_stride;
`endif
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      line_addr_q   <= '0;
      line_idx_q    <= '0;
      px_left_q     <= '0;
      hres_q        <= '0;
      vres_q        <= '0;
      rd_req_q      <= 1'b0;
      rd_addr_q     <= '0;
      rd_len_q      <= '0;
      busy_q        <= 1'b0;
      go_pend_q     <= 1'b0;
      stop_pend_q   <= 1'b0;
      frame_count_q <= '0;
`ifdef HDMI_FETCH_DBLBUF_EN
      stride_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      line_addr_q   <= line_addr_d;
      line_idx_q    <= line_idx_d;
      px_left_q     <= px_left_d;
      hres_q        <= hres_d;
      vres_q        <= vres_d;
      rd_req_q      <= rd_req_d;
      rd_addr_q     <= rd_addr_d;
      rd_len_q      <= rd_len_d;
      busy_q        <= busy_d;
      go_pend_q     <= go_pend_d;
      stop_pend_q   <= stop_pend_d;
      frame_count_q <= frame_count_d;
`ifdef HDMI_FETCH_DBLBUF_EN
      stride_q      <= stride_d;
`endif
    end
  end

  assign rd_req      = rd_req_q;
  assign rd_addr     = rd_addr_q;
  assign rd_len      = rd_len_q;
  assign busy        = busy_q;
  assign frame_count = frame_count_q;

endmodule

`default_nettype wire

// File: tb/tb_hdmi_fetch_ctrl.sv
// tb_hdmi_fetch_ctrl -- scoreboard bench: expected bursts per frame plus credit/underflow model.
// Rev 1.0
`default_nettype none

module tb_hdmi_fetch_ctrl;

  localparam int DEPTH = 512;
  localparam int BEATS = 64;

  logic        clock;
  logic        reset_n;
  logic        enable;
  logic [31:0] frame_base;
  logic [15:0] line_stride;
  logic [10:0] hres;
  logic [10:0] vres;
  logic        read_go;
  logic        read_done;
  logic        read_fifo = 1'b0;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic [7:0]  rd_len;
  logic        rd_ack = 1'b0;
  logic        busy;
  logic        underflow;
  logic [15:0] frame_count;

  hdmi_fetch_ctrl #(
    .ADDR_W      (32),
    .BURST_BEATS (BEATS),
    .FIFO_DEPTH  (DEPTH)
  ) u_dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .frame_base  (frame_base),
    .line_stride (line_stride),
    .hres        (hres),
    .vres        (vres),
    .read_go     (read_go),
    .read_done   (read_done),
    .read_fifo   (read_fifo),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_len      (rd_len),
    .rd_ack      (rd_ack),
    .busy        (busy),
    .underflow   (underflow),
    .frame_count (frame_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    int          len;
  } burst_t;

  burst_t      exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          n_hs  = 0;
  int          m_credit = 0;
  bit          m_uf = 0;
  int          m_frames = 0;
  bit          live_chk = 0;
  bit          force_pop = 0;
  bit          pop_mode = 0;
  int          pop_pct = 50;
  bit          ack_rand = 0;
  bit          ack_fix = 0;
  bit          pend = 0;
  logic [31:0] p_base;
  logic [15:0] p_stride;
  int          p_h, p_v;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Whole-frame burst list: each line split into ceil(h/BEATS) bursts
  function automatic void push_frame(input logic [31:0] base, input logic [15:0] stride,
                                     input int h, input int v);
    burst_t b;
    exp_q.delete();
    for (int ln = 0; ln < v; ln++) begin
      for (int off = 0; off < h; off += BEATS) begin
        b.addr = base + 32'(ln) * 32'(stride) + 32'(4 * off);
        b.len  = (h - off < BEATS) ? (h - off) : BEATS;
        exp_q.push_back(b);
      end
    end
  endfunction

  // Scoreboard / reference model, observed at the active edge
  always @(posedge clock or negedge reset_n) begin
    int     pre, l;
    bit     hs, go;
    burst_t e;
    if (!reset_n) begin
      exp_q.delete();
      m_credit = 0;
      m_uf     = 0;
      pend     = 0;
    end else begin
      pre = m_credit;
      l   = 0;
      hs  = rd_req && rd_ack;
      go  = read_go && enable;
      if (hs) begin
        n_hs++;
        if (exp_q.size() == 0) check("unexpected_req", 64'(1), 64'(0));
        else begin
          e = exp_q.pop_front();
          check("rd_addr", 64'(rd_addr), 64'(e.addr));
          check("rd_len", 64'(rd_len), 64'(e.len));
          check("credit_room", 64'(pre + e.len <= DEPTH), 64'(1));
          l = e.len;
        end
      end
      m_credit += l;
      if (read_fifo) begin
        if (pre == 0) m_uf = 1;
        else          m_credit--;
      end
      if (go && rd_req && !rd_ack) begin
        pend     = 1;
        p_base   = frame_base;
        p_stride = line_stride;
        p_h      = int'(hres);
        p_v      = int'(vres);
      end else if (go) begin
        push_frame(frame_base, line_stride, int'(hres), int'(vres));
        pend = 0;
      end else if (hs && pend) begin
        push_frame(p_base, p_stride, p_h, p_v);
        pend = 0;
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n && live_chk) begin
      check("credit", 64'(u_dut.credit), 64'(m_credit));
      check("underflow", 64'(underflow), 64'(m_uf));
    end
  end

  // Memory-side ack and consumer pops
  always @(posedge clock) begin
    #2;
    rd_ack    = ack_rand ? ($urandom_range(0, 2) != 0) : ack_fix;
    read_fifo = force_pop || (pop_mode && m_credit > 0 && $urandom_range(0, 99) < pop_pct);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse_go();
    read_go = 1'b1;
    tick(1);
    read_go = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int c = 0;
    while (!rd_req && c < 2000) begin
      @(negedge clock);
      c++;
    end
    if (!rd_req) check(name, 64'(rd_req), 64'(1));
  endtask

  task automatic finish_frame(input int limit);
    int c = 0;
    tick(1);
    while (exp_q.size() != 0 && c < limit) begin
      tick(1);
      c++;
    end
    if (exp_q.size() != 0) check("frame_timeout", 64'(exp_q.size()), 64'(0));
    tick(3);
    check("busy_drain", 64'(busy), 64'(1));
    read_done = 1'b1;
    tick(1);
    read_done = 1'b0;
    m_frames++;
    @(negedge clock);
    check("frame_count", 64'(frame_count), 64'(m_frames));
    check("busy_idle", 64'(busy), 64'(0));
    tick(1);
  endtask

  task automatic check_reset_outputs();
    check("rst_rd_req", 64'(rd_req), 64'(0));
    check("rst_rd_addr", 64'(rd_addr), 64'(0));
    check("rst_rd_len", 64'(rd_len), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_underflow", 64'(underflow), 64'(0));
    check("rst_frame_count", 64'(frame_count), 64'(0));
  endtask

  initial begin
    int hs0, hs1, c;
    int ht[6];
    int vt[6];
    reset_n = 1'b0; enable = 1'b0; frame_base = '0; line_stride = '0;
    hres = '0; vres = '0; read_go = 1'b0; read_done = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs();
    reset_n  = 1'b1;
    live_chk = 1;

    // Underflow: pop with zero credit, sticky until reset
    tick(2);
    force_pop = 1; tick(1); force_pop = 0;
    tick(5);
    check("underflow_sticky", 64'(underflow), 64'(1));
    reset_n = 1'b0;
    #1;
    check("underflow_cleared", 64'(underflow), 64'(0));
    tick(1);
    reset_n = 1'b1;
    tick(2);

    // 800x2, ack tied high, no pops: credit limit after 8 bursts
    enable = 1'b1; frame_base = 32'h1000_0000; line_stride = 16'h1000;
    hres = 11'd800; vres = 11'd2; ack_fix = 1;
    hs0 = n_hs;
    pulse_go();
    @(negedge clock);
    check("go_busy_n1", 64'(busy), 64'(1));
    check("go_req_n1", 64'(rd_req), 64'(0));
    @(negedge clock);
    check("go_req_n2", 64'(rd_req), 64'(1));
    check("go_addr_n2", 64'(rd_addr), 64'h1000_0000);
    tick(60);
    check("bursts_at_limit", 64'(n_hs - hs0), 64'(8));
    force_pop = 1; tick(1); force_pop = 0;
    tick(10);
    check("one_pop_no_req", 64'(n_hs - hs0), 64'(8));
    force_pop = 1; tick(63); force_pop = 0;
    tick(10);
    check("64_pops_one_req", 64'(n_hs - hs0), 64'(9));
    pop_mode = 1; pop_pct = 50;
    finish_frame(20000);
    check("frame_800x2_bursts", 64'(n_hs - hs0), 64'(26));

    // Stalled handshake, then restart requested mid-REQ
    ack_fix = 0; frame_base = 32'h0000_2000; line_stride = 16'h0400;
    hres = 11'd100; vres = 11'd3;
    pulse_go();
    wait_req("stall_req_timeout");
    repeat (10) begin
      @(negedge clock);
      check("stall_req", 64'(rd_req), 64'(1));
      if (exp_q.size() != 0) begin
        check("stall_addr", 64'(rd_addr), 64'(exp_q[0].addr));
        check("stall_len", 64'(rd_len), 64'(exp_q[0].len));
      end
    end
    @(posedge clock);
    #1;
    frame_base = 32'h0000_3000; hres = 11'd200; vres = 11'd2;
    pulse_go();
    tick(2);
    hs1 = n_hs; ack_fix = 1; c = 0;
    while (n_hs == hs1 && c < 10) begin
      tick(1);
      c++;
    end
    check("restart_old_burst_done", 64'(n_hs - hs1), 64'(1));
    wait_req("restart_req_timeout");
    check("restart_addr", 64'(rd_addr), 64'h0000_3000);
    check("restart_len", 64'(rd_len), 64'(64));
    ack_rand = 1;
    finish_frame(20000);

    // Random and boundary frame shapes, including address wrap
    ht = '{1, 64, 65, 2047, 0, 0};
    vt = '{1, 2, 3, 1, 0, 0};
    for (int i = 0; i < 6; i++) begin
      hres        = (ht[i] == 0) ? 11'($urandom_range(1, 300)) : 11'(ht[i]);
      vres        = (vt[i] == 0) ? 11'($urandom_range(1, 6)) : 11'(vt[i]);
      frame_base  = (i == 3) ? 32'hFFFF_F800 : $urandom;
      line_stride = 16'($urandom_range(0, 65535));
      pulse_go();
      finish_frame(20000);
    end

    // Full-rate 640x40 frame with continuous consumer
    ack_rand = 0; ack_fix = 1; pop_pct = 100;
    frame_base = 32'h4000_0000; line_stride = 16'd2560; hres = 11'd640; vres = 11'd40;
    hs0 = n_hs;
    pulse_go();
    finish_frame(60000);
    check("full_frame_bursts", 64'(n_hs - hs0), 64'(400));

    // Asynchronous reset mid-frame
    pulse_go();
    tick(50);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs();
    m_frames = 0;
    tick(2);
    reset_n = 1'b1;
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, actual running required finished");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
